tdma_dispatcher: RTL

- Downstream consumer of the TDMA slot scheduler. Takes the scheduler's valid/selection each cycle and grants exactly one of NUMBER_OF_QUEUES per-core request queues.
- Forwards the granted request through a single registered output stage to the memory-side port.
- Keeps per-queue served-request counters for bandwidth accounting.
- Optional work-conserving mode hands an idle slot to another queue in round-robin order.

---
 rtl/tdma_dispatcher.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/tdma_dispatcher.sv
// rtl/tdma_dispatcher.sv - TDMA slot dispatcher with registered output stage and served counters
//
// Grants one of NUMBER_OF_QUEUES request queues per cycle according to the
// scheduler's slot selection, forwards the accepted request through a single
// output register, and keeps a saturating served-request counter per queue.
// With WORK_CONSERVING=1 an idle slot is handed round-robin to another queue.
//
// Ports:
//   clock_i            rising-edge clock
//   reset_i            asynchronous reset, active low
//   sched_valid_i      scheduler selection valid this cycle
//   sched_selection_i  queue owning the current slot
//   in_valid_i         per-queue request present
//   in_data_i          per-queue request payload
//   in_ready_o         per-queue accept (one-hot or zero)
//   out_valid_o        output register holds a request
//   out_data_o         forwarded payload
//   out_queue_o        source queue of out_data_o
//   out_ready_i        downstream accepts the output this cycle
//   clear_counters_i   synchronous clear of all served counters
//   served_count_o     accepted-request count per queue
module tdma_dispatcher #(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int DATA_WIDTH       = 64,
    parameter int REGISTER_SIZE    = 32,
    parameter int WORK_CONSERVING  = 0,
    localparam int SEL_W = (NUMBER_OF_QUEUES > 1) ? $clog2(NUMBER_OF_QUEUES) : 1
) (
    input  logic                                            clock_i,
    input  logic                                            reset_i,
    input  logic                                            sched_valid_i,
    input  logic [SEL_W-1:0]                                sched_selection_i,
    input  logic [NUMBER_OF_QUEUES-1:0]                     in_valid_i,
    input  logic [NUMBER_OF_QUEUES-1:0][DATA_WIDTH-1:0]     in_data_i,
    output logic [NUMBER_OF_QUEUES-1:0]                     in_ready_o,
    output logic                                            out_valid_o,
    output logic [DATA_WIDTH-1:0]                           out_data_o,
    output logic [SEL_W-1:0]                                out_queue_o,
    input  logic                                            out_ready_i,
    input  logic                                            clear_counters_i,
    output logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0]  served_count_o
);

    logic                                           out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]                          out_data_q, out_data_d;
    logic [SEL_W-1:0]                               out_queue_q, out_queue_d;
    logic [NUMBER_OF_QUEUES-1:0][REGISTER_SIZE-1:0] served_q, served_d;
    logic [SEL_W-1:0]                               rr_ptr_q, rr_ptr_d;

    logic                        stage_free;
    logic [NUMBER_OF_QUEUES-1:0] grant;
    logic [SEL_W-1:0]            grant_idx;
    logic                        transfer;

    assign stage_free = ~out_valid_q | out_ready_i;

    // Grant selection. The primary loop compares against every legal index,
    // so a selection >= NUMBER_OF_QUEUES simply matches nothing.
    always_comb begin
        logic found;
        int   k;
        grant     = '0;
        grant_idx = '0;
        rr_ptr_d  = rr_ptr_q;
        found     = 1'b0;
        k         = 0;
        if (sched_valid_i && stage_free) begin
            for (int p = 0; p < NUMBER_OF_QUEUES; p++) begin
                if (sched_selection_i == SEL_W'(p) && in_valid_i[p]) begin
                    grant[p]  = 1'b1;
                    grant_idx = SEL_W'(p);
                    found     = 1'b1;
                end
            end
            if (WORK_CONSERVING != 0 && !found) begin
                for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
                    k = (int'(rr_ptr_q) + i) % NUMBER_OF_QUEUES;
                    if (!found && in_valid_i[k]) begin
                        found     = 1'b1;
                        grant[k]  = 1'b1;
                        grant_idx = SEL_W'(k);
                        rr_ptr_d  = SEL_W'((k + 1) % NUMBER_OF_QUEUES);
                    end
                end
            end
        end
    end

    assign transfer   = |grant;
    // No queue may see an accept while the block is held in reset.
    assign in_ready_o = reset_i ? grant : '0;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_queue_d = out_queue_q;
        if (transfer) begin
            out_valid_d = 1'b1;
            out_queue_d = grant_idx;
            for (int p = 0; p < NUMBER_OF_QUEUES; p++) begin
                if (grant[p]) begin
                    out_data_d = in_data_i[p];
                end
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // Clear wins over a same-cycle transfer; counts saturate at all-ones.
    always_comb begin
        served_d = served_q;
        for (int g = 0; g < NUMBER_OF_QUEUES; g++) begin
            if (clear_counters_i) begin
                served_d[g] = '0;
            end else if (grant[g] && served_q[g] != '1) begin
                served_d[g] = served_q[g] + REGISTER_SIZE'(1);
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_queue_q <= '0;
            served_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_queue_q <= out_queue_d;
            served_q    <= served_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid_o    = out_valid_q;
    assign out_data_o     = out_data_q;
    assign out_queue_o    = out_queue_q;
    assign served_count_o = served_q;

endmodule
